mult4_seq: RTL and testbench



---
 rtl/mult4_seq_pkg.sv | 15 +
 rtl/add_n_cout.sv | 23 ++
 rtl/mult4_seq.sv | 89 ++++++++
 tb/tb_mult4_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mult4_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult4_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter width able to hold 0..n
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/add_n_cout.sv
// N-bit ripple-carry adder built from a chain of full-adder cells, carry out kept.
module add_n_cout #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    output logic [N-1:0] S,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/mult4_seq.sv
// Sequential unsigned shift-and-add multiplier: one shared N-bit adder over N iterations.
module mult4_seq
    import mult4_seq_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CW = cnt_width(N);

    state_t          state;
    logic [N-1:0]    mcand;
    logic [N-1:0]    acc_hi;
    logic [N-1:0]    mq;
    logic [CW-1:0]   cnt;

    logic [N-1:0]    addend;
    logic [N-1:0]    sum_s;
    logic            sum_c;
    logic [N:0]      sum;

    // Partial product selected by the current multiplier LSB
    assign addend = mq[0] ? mcand : '0;
    assign sum    = {sum_c, sum_s};

    add_n_cout #(.N(N)) u_add (
        .A    (acc_hi),
        .B    (addend),
        .cin  (1'b0),
        .S    (sum_s),
        .cout (sum_c)
    );

    // Controller, counter and 2N+1-bit shift path; carry enters the shifted MSB
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            mcand   <= '0;
            acc_hi  <= '0;
            mq      <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mq     <= b;
                        acc_hi <= '0;
                        cnt    <= '0;
                        state  <= S_CALC;
                        busy   <= 1'b1;
                    end
                end
                S_CALC: begin
                    acc_hi <= sum[N:1];
                    mq     <= {sum[0], mq[N-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        product <= {sum, mq[N-1:1]};
                        state   <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult4_seq.sv
// Scoreboard bench for mult4_seq: driver queues expected products, monitor checks each done.
module tb_mult4_seq;

    localparam int unsigned N = 4;

    typedef struct {
        int unsigned exp;
        int unsigned due;
    } exp_t;

    logic           clk = 1'b0;
    logic           resetn;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          errors = 0;

    mult4_seq #(.N(N)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done must match the oldest outstanding request, on time
    always @(negedge clk) begin
        if (resetn === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: cycle %0d product %0d, no request outstanding", cyc, product);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (product !== 8'(e.exp)) begin
                    errors++;
                    $display("FAIL product: got %0d expected %0d", product, e.exp);
                end
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL latency: done at cycle %0d expected %0d", cyc, e.due);
                end
            end
        end
    end

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
        end
    endtask

    // Issue one start pulse at a negedge; the next posedge is the accepting edge
    task automatic issue(input int unsigned av, input int unsigned bv);
        a     = N'(av);
        b     = N'(bv);
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{exp: av * bv, due: cyc + 4});
        vectors++;
        start = 1'b0;
    endtask

    task automatic run_op(input int unsigned av, input int unsigned bv);
        wait_idle();
        issue(av, bv);
    endtask

    initial begin
        int bcnt;
        resetn = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_product", 32'(product), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Basic product plus busy-width check
        run_op(13, 11);
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
        end
        check("busy_cycles", 32'(bcnt), 5);

        run_op(15, 15);
        run_op(0, 9);
        run_op(7, 0);

        // Start while busy is ignored
        run_op(9, 14);
        @(negedge clk);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset mid-operation aborts without a done
        run_op(6, 5);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        check("abort_product", 32'(product), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        run_op(6, 5);

        // Back-to-back with start held through DONE
        wait_idle();
        a = 4'd3; b = 4'd4; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{exp: 12, due: cyc + 4});
        vectors++;
        repeat (4) @(posedge clk);
        #1;
        a = 4'd2; b = 4'd9;
        @(posedge clk);
        @(posedge clk);
        #1;
        sb.push_back('{exp: 18, due: cyc + 4});
        vectors++;
        start = 1'b0;

        // Random operands
        for (int i = 0; i < 24; i++) begin
            run_op($urandom_range(0, 15), $urandom_range(0, 15));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
